te_block_serializer: RTL and testbench
======================================

// Module: te_block_serializer
// PURPOSE
// Schedules the up-to-N parallel blocks emitted per cycle by the CVA6 trace connector onto one
// single-lane trace-encoder input. It captures a block group, then issues its valid slots one per
// handshake, lowest index first. Cause/tval/priv are shared per group. It sits between the
// connector outputs and the trace encoder, and gives backpressure plus drop accounting.
// PARAMETERS
// N            1   max blocks per group (must match the connector N); >=1
// DROP_CNT_W   16  width of the saturating dropped-group counter
// PORTS
// clk_i         in   1                      clock; all state updates on posedge
// rst_ni        in   1                      synchronous active-low reset
// valid_i       in   N                      per-slot block valid from the connector
// iretire_i     in   N x IRETIRE_LEN        per-slot retired halfword count
// ilastsize_i   in   N                      per-slot last-instruction size
// itype_i       in   N x ITYPE_LEN          per-slot itype
// iaddr_i       in   N x XLEN               per-slot block address
// cause_i       in   XLEN                   group cause; meaningful for itype 1/2
// tval_i        in   XLEN                   group tval; meaningful for itype 1/2
// priv_i        in   PRIV_LEN               group privilege
// ready_o       out  1                      group can be accepted this cycle
// te_valid_o    out  1                      block presented to the encoder
// te_ready_i    in   1                      encoder accepts the block
// te_iretire_o  out  IRETIRE_LEN            presented iretire
// te_ilastsize_o out 1                      presented ilastsize
// te_itype_o    out  ITYPE_LEN              presented itype
// te_iaddr_o    out  XLEN                   presented iaddr
// te_cause_o    out  XLEN                   cause if te_itype_o is 1 or 2, else 0
// te_tval_o     out  XLEN                   tval if te_itype_o is 1 or 2, else 0
// te_priv_o     out  PRIV_LEN               captured group priv
// drop_o        out  1                      pulse: group offered while ready_o=0 (lost)
// drop_cnt_o    out  DROP_CNT_W             saturating count of drop_o pulses
// BEHAVIOUR
// - Reset (rst_ni=0 at posedge): state IDLE, pending mask 0, all holding regs 0, drop_cnt 0.
//   All te_* outputs are 0 and drop_o is 0. ready_o is 1 after reset.
// - Group offered = |valid_i. accept = offered && ready_o.
// - Capture on accept: slot regs <- inputs for all N; pending mask <- valid_i; cause/tval/priv
//   are registered.
// - FSM IDLE: ready_o=1, te_valid_o=0. On accept go to ISSUE; otherwise stay.
// - FSM ISSUE: te_valid_o=1. Presented slot = lowest set bit of the pending mask.
//   te_* outputs are driven from the registered slot and group regs.
// - Latency: a group accepted at cycle t presents its first block at t+1.
// - Handshake: hs = te_valid_o && te_ready_i. On hs the presented bit is cleared.
// - te_* outputs stay stable while te_valid_o && !te_ready_i.
// - last = hs && pending mask has exactly one bit set.
//   ready_o = (state==IDLE) || last. This is a combinational path from te_ready_i.
// - On last with accept: reload the mask and regs and stay in ISSUE (back-to-back, no bubble).
//   On last without accept: go to IDLE.
// - Non-contiguous valid_i (e.g. 2'b10) issues only the set slots; slot 0 is skipped.
// - In IDLE, |valid_i==0 is ignored: no capture, no drop.
// - drop_o = offered && !ready_o, combinational. drop_cnt increments on drop_o.
//   drop_cnt holds at 2^DROP_CNT_W-1 and never wraps.
// - te_cause_o and te_tval_o are zeroed unless te_itype_o is 1 or 2.
//   te_priv_o is always the group priv.
// - N=1: degenerates to a 1-deep registered pipe with the same handshake.
// TESTING
// 1. Reset, then valid_i=2'b11 with iaddr {0x200,0x100}, te_ready_i=1
//    -> beats iaddr 0x100 then 0x200 at t+1 and t+2; ready_o=1 at t+2; then IDLE.
// 2. valid_i=2'b10, itype_i[1]=1, cause=0x5, tval=0xBAD
//    -> single beat with itype 1, cause 0x5, tval 0xBAD.
//    Then a group with itype 4 -> cause_o=tval_o=0.
// 3. te_ready_i=0 for 5 cycles mid-group -> te_* outputs are stable and ready_o=0.
//    A group offered then gives drop_o=1 and drop_cnt_o=1.
// 4. Back-to-back: new group held on valid_i while the last beat handshakes
//    -> accepted the same cycle, and its first beat follows with no te_valid_o gap.
// 5. Assert rst_ni=0 during ISSUE with the mask at 2'b10
//    -> next cycle te_valid_o=0, ready_o=1, drop_cnt_o=0, and no stale beat afterwards.
// 6. DROP_CNT_W=2 and 5 drops -> drop_cnt_o saturates at 3.

Source files
------------

// File: rtl/te_block_serializer.sv
// Serializes a group of up to N parallel trace blocks onto one encoder lane,
// lowest slot first, with backpressure and a saturating dropped-group counter.
module te_block_serializer #(
  parameter int N           = 1,
  parameter int DROP_CNT_W  = 16,
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N-1:0]                        valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0]       iretire_i,
  input  logic [N-1:0]                        ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]         itype_i,
  input  logic [N-1:0][XLEN-1:0]              iaddr_i,
  input  logic [XLEN-1:0]                     cause_i,
  input  logic [XLEN-1:0]                     tval_i,
  input  logic [PRIV_LEN-1:0]                 priv_i,
  output logic                                ready_o,
  output logic                                te_valid_o,
  input  logic                                te_ready_i,
  output logic [IRETIRE_LEN-1:0]              te_iretire_o,
  output logic                                te_ilastsize_o,
  output logic [ITYPE_LEN-1:0]                te_itype_o,
  output logic [XLEN-1:0]                     te_iaddr_o,
  output logic [XLEN-1:0]                     te_cause_o,
  output logic [XLEN-1:0]                     te_tval_o,
  output logic [PRIV_LEN-1:0]                 te_priv_o,
  output logic                                drop_o,
  output logic [DROP_CNT_W-1:0]               drop_cnt_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [N-1:0]                    mask_q, mask_d;
  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_q, iretire_d;
  logic [N-1:0]                    ilastsize_q, ilastsize_d;
  logic [N-1:0][ITYPE_LEN-1:0]     itype_q, itype_d;
  logic [N-1:0][XLEN-1:0]          iaddr_q, iaddr_d;
  logic [XLEN-1:0]                 cause_q, cause_d;
  logic [XLEN-1:0]                 tval_q, tval_d;
  logic [PRIV_LEN-1:0]             priv_q, priv_d;
  logic [DROP_CNT_W-1:0]           drop_cnt_q, drop_cnt_d;

  logic                            te_valid_q, te_valid_d;
  logic [IRETIRE_LEN-1:0]          te_iretire_q, te_iretire_d;
  logic                            te_ilastsize_q, te_ilastsize_d;
  logic [ITYPE_LEN-1:0]            te_itype_q, te_itype_d;
  logic [XLEN-1:0]                 te_iaddr_q, te_iaddr_d;
  logic [XLEN-1:0]                 te_cause_q, te_cause_d;
  logic [XLEN-1:0]                 te_tval_q, te_tval_d;
  logic [PRIV_LEN-1:0]             te_priv_q, te_priv_d;

  logic                            offered_s, hs_s, single_s, last_s;
  logic                            ready_s, accept_s, drop_s;
  logic [IDX_W-1:0]                sel_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Handshake, group acceptance and drop detection
  always_comb begin
    offered_s = |valid_i;
    hs_s      = te_valid_q && te_ready_i;
    single_s  = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);
    last_s    = hs_s && single_s;
    ready_s   = (state_q == IDLE) || last_s;
    accept_s  = offered_s && ready_s;
    drop_s    = offered_s && !ready_s;
  end

  // Next-state: capture, slot retirement and drop counter
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    iretire_d   = iretire_q;
    ilastsize_d = ilastsize_q;
    itype_d     = itype_q;
    iaddr_d     = iaddr_q;
    cause_d     = cause_q;
    tval_d      = tval_q;
    priv_d      = priv_q;
    if (accept_s) begin
      state_d     = ISSUE;
      mask_d      = valid_i;
      iretire_d   = iretire_i;
      ilastsize_d = ilastsize_i;
      itype_d     = itype_i;
      iaddr_d     = iaddr_i;
      cause_d     = cause_i;
      tval_d      = tval_i;
      priv_d      = priv_i;
    end else if (hs_s) begin
      // Clearing the lowest set bit retires exactly the slot being presented.
      mask_d  = mask_q & (mask_q - N'(1));
      state_d = last_s ? IDLE : ISSUE;
    end else begin
      state_d = state_q;
    end

    if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Presented beat for next cycle, selected from the next-state slot regs
  always_comb begin
    sel_s          = lowest_set(mask_d);
    te_valid_d     = 1'b0;
    te_iretire_d   = '0;
    te_ilastsize_d = 1'b0;
    te_itype_d     = '0;
    te_iaddr_d     = '0;
    te_cause_d     = '0;
    te_tval_d      = '0;
    te_priv_d      = '0;
    case (state_d)
      ISSUE: begin
        te_valid_d     = 1'b1;
        te_iretire_d   = iretire_d[sel_s];
        te_ilastsize_d = ilastsize_d[sel_s];
        te_itype_d     = itype_d[sel_s];
        te_iaddr_d     = iaddr_d[sel_s];
        te_priv_d      = priv_d;
        if ((itype_d[sel_s] == ITYPE_LEN'(1)) || (itype_d[sel_s] == ITYPE_LEN'(2))) begin
          te_cause_d = cause_d;
          te_tval_d  = tval_d;
        end else begin
          te_cause_d = '0;
          te_tval_d  = '0;
        end
      end
      default: begin
        te_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      iretire_q      <= '0;
      ilastsize_q    <= '0;
      itype_q        <= '0;
      iaddr_q        <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      priv_q         <= '0;
      drop_cnt_q     <= '0;
      te_valid_q     <= 1'b0;
      te_iretire_q   <= '0;
      te_ilastsize_q <= 1'b0;
      te_itype_q     <= '0;
      te_iaddr_q     <= '0;
      te_cause_q     <= '0;
      te_tval_q      <= '0;
      te_priv_q      <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      iretire_q      <= iretire_d;
      ilastsize_q    <= ilastsize_d;
      itype_q        <= itype_d;
      iaddr_q        <= iaddr_d;
      cause_q        <= cause_d;
      tval_q         <= tval_d;
      priv_q         <= priv_d;
      drop_cnt_q     <= drop_cnt_d;
      te_valid_q     <= te_valid_d;
      te_iretire_q   <= te_iretire_d;
      te_ilastsize_q <= te_ilastsize_d;
      te_itype_q     <= te_itype_d;
      te_iaddr_q     <= te_iaddr_d;
      te_cause_q     <= te_cause_d;
      te_tval_q      <= te_tval_d;
      te_priv_q      <= te_priv_d;
    end
  end

  assign ready_o        = ready_s;
  assign drop_o         = drop_s;
  assign drop_cnt_o     = drop_cnt_q;
  assign te_valid_o     = te_valid_q;
  assign te_iretire_o   = te_iretire_q;
  assign te_ilastsize_o = te_ilastsize_q;
  assign te_itype_o     = te_itype_q;
  assign te_iaddr_o     = te_iaddr_q;
  assign te_cause_o     = te_cause_q;
  assign te_tval_o      = te_tval_q;
  assign te_priv_o      = te_priv_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Bench for te_block_serializer: directed scenarios plus random traffic, all
// checked against a queue-of-beats reference model.
module tb_te_block_serializer;

  localparam int N  = 2;
  localparam int DW = 2;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      valid_i;
  logic [N-1:0][7:0] iretire_i;
  logic [N-1:0]      ilastsize_i;
  logic [N-1:0][2:0] itype_i;
  logic [N-1:0][31:0] iaddr_i;
  logic [31:0]       cause_i, tval_i;
  logic [1:0]        priv_i;
  logic              ready_o, te_valid_o, te_ready_i;
  logic [7:0]        te_iretire_o;
  logic              te_ilastsize_o;
  logic [2:0]        te_itype_o;
  logic [31:0]       te_iaddr_o, te_cause_o, te_tval_o;
  logic [1:0]        te_priv_o;
  logic              drop_o;
  logic [DW-1:0]     drop_cnt_o;

  te_block_serializer #(
    .N(N), .DROP_CNT_W(DW), .XLEN(32), .IRETIRE_LEN(8), .ITYPE_LEN(3), .PRIV_LEN(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .iretire_i(iretire_i),
    .ilastsize_i(ilastsize_i), .itype_i(itype_i), .iaddr_i(iaddr_i),
    .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .ready_o(ready_o),
    .te_valid_o(te_valid_o), .te_ready_i(te_ready_i), .te_iretire_o(te_iretire_o),
    .te_ilastsize_o(te_ilastsize_o), .te_itype_o(te_itype_o), .te_iaddr_o(te_iaddr_o),
    .te_cause_o(te_cause_o), .te_tval_o(te_tval_o), .te_priv_o(te_priv_o),
    .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  iretire;
    logic        ils;
    logic [2:0]  itype;
    logic [31:0] iaddr;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [1:0]  priv;
  } beat_t;

  beat_t q[$];
  int    exp_cnt  = 0;
  bit    model_ok = 1'b0;
  int    n_chk    = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare DUT against the model, advance the model, move to the next negedge.
  task automatic step();
    bit    exp_valid, exp_ready, offered;
    beat_t b;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || ((q.size() == 1) && te_ready_i);
    offered   = |valid_i;
    if (model_ok) begin
      chk("te_valid", 64'(te_valid_o), 64'(exp_valid));
      chk("ready", 64'(ready_o), 64'(exp_ready));
      chk("drop", 64'(drop_o), 64'(offered && !exp_ready));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(exp_cnt));
      if (exp_valid) begin
        b = q[0];
        chk("iretire", 64'(te_iretire_o), 64'(b.iretire));
        chk("ilastsize", 64'(te_ilastsize_o), 64'(b.ils));
        chk("itype", 64'(te_itype_o), 64'(b.itype));
        chk("iaddr", 64'(te_iaddr_o), 64'(b.iaddr));
        chk("cause", 64'(te_cause_o), (b.itype == 3'd1 || b.itype == 3'd2) ? 64'(b.cause) : 64'd0);
        chk("tval", 64'(te_tval_o), (b.itype == 3'd1 || b.itype == 3'd2) ? 64'(b.tval) : 64'd0);
        chk("priv", 64'(te_priv_o), 64'(b.priv));
      end
    end
    if (!rst_ni) begin
      q.delete();
      exp_cnt  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (exp_valid && te_ready_i) void'(q.pop_front());
      if (offered && exp_ready) begin
        for (int i = 0; i < N; i++) begin
          if (valid_i[i]) begin
            b.iretire = iretire_i[i]; b.ils = ilastsize_i[i]; b.itype = itype_i[i];
            b.iaddr = iaddr_i[i]; b.cause = cause_i; b.tval = tval_i; b.priv = priv_i;
            q.push_back(b);
          end
        end
      end
      if (offered && !exp_ready && exp_cnt < (2 ** DW) - 1) exp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic set_group(input logic [N-1:0] v, input logic [31:0] a1, input logic [31:0] a0);
    valid_i = v;
    iaddr_i[1] = a1; iaddr_i[0] = a0;
    iretire_i[1] = 8'h22; iretire_i[0] = 8'h11;
    ilastsize_i = 2'b10;
    itype_i[1] = 3'd0; itype_i[0] = 3'd0;
    cause_i = 32'h0; tval_i = 32'h0; priv_i = 2'd3;
  endtask

  initial begin
    rst_ni = 1'b0; te_ready_i = 1'b1;
    set_group(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // 1: reset state, then a two-slot group
    step();
    chk("rst_te_valid", 64'(te_valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    chk("rst_iaddr", 64'(te_iaddr_o), 64'd0);
    rst_ni = 1'b1;
    step();
    set_group(2'b11, 32'h200, 32'h100);
    step();
    valid_i = 2'b00;
    chk("t1_beat0", 64'(te_iaddr_o), 64'h100);
    step();
    chk("t1_beat1", 64'(te_iaddr_o), 64'h200);
    chk("t1_ready_last", 64'(ready_o), 64'd1);
    step();
    chk("t1_idle", 64'(te_valid_o), 64'd0);

    // 2: non-contiguous group with itype 1, then itype 4 gating
    set_group(2'b10, 32'h300, 32'hDEAD);
    itype_i[1] = 3'd1; cause_i = 32'h5; tval_i = 32'hBAD;
    step();
    valid_i = 2'b00;
    chk("t2_iaddr", 64'(te_iaddr_o), 64'h300);
    chk("t2_itype", 64'(te_itype_o), 64'd1);
    chk("t2_cause", 64'(te_cause_o), 64'h5);
    chk("t2_tval", 64'(te_tval_o), 64'hBAD);
    step();
    chk("t2_single", 64'(te_valid_o), 64'd0);
    set_group(2'b01, 32'h0, 32'h400);
    itype_i[0] = 3'd4; cause_i = 32'h7; tval_i = 32'h9;
    step();
    valid_i = 2'b00;
    chk("t2_itype4", 64'(te_itype_o), 64'd4);
    chk("t2_cause0", 64'(te_cause_o), 64'd0);
    chk("t2_tval0", 64'(te_tval_o), 64'd0);
    step();

    // 3: stall mid-group, then a dropped group
    set_group(2'b11, 32'h600, 32'h500);
    te_ready_i = 1'b0;
    step();
    valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stable", 64'(te_iaddr_o), 64'h500);
      chk("t3_ready0", 64'(ready_o), 64'd0);
      step();
    end
    valid_i = 2'b01;
    #1;
    chk("t3_drop", 64'(drop_o), 64'd1);
    step();
    valid_i = 2'b00;
    chk("t3_drop_cnt", 64'(drop_cnt_o), 64'd1);
    te_ready_i = 1'b1;
    step(); step();

    // 4: back-to-back groups with no bubble
    set_group(2'b11, 32'h800, 32'h700);
    step();
    valid_i = 2'b00;
    step();
    set_group(2'b11, 32'hA00, 32'h900);
    #1;
    chk("t4_ready", 64'(ready_o), 64'd1);
    chk("t4_nodrop", 64'(drop_o), 64'd0);
    step();
    valid_i = 2'b00;
    chk("t4_nogap", 64'(te_valid_o), 64'd1);
    chk("t4_next", 64'(te_iaddr_o), 64'h900);
    step(); step();
    chk("t4_idle", 64'(te_valid_o), 64'd0);

    // 5: reset while the second slot is pending
    set_group(2'b11, 32'hC00, 32'hB00);
    te_ready_i = 1'b0;
    step();
    valid_i = 2'b00; te_ready_i = 1'b1;
    step();
    rst_ni = 1'b0; te_ready_i = 1'b0;
    step();
    chk("t5_valid", 64'(te_valid_o), 64'd0);
    chk("t5_ready", 64'(ready_o), 64'd1);
    chk("t5_cnt", 64'(drop_cnt_o), 64'd0);
    rst_ni = 1'b1; te_ready_i = 1'b1;
    step(); step();
    chk("t5_no_stale", 64'(te_valid_o), 64'd0);

    // 6: drop counter saturation
    set_group(2'b01, 32'h0, 32'hD00);
    te_ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    valid_i = 2'b00;
    chk("t6_sat", 64'(drop_cnt_o), 64'd3);
    te_ready_i = 1'b1;
    step(); step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_ni = ($urandom_range(0, 299) != 0);
      valid_i = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin
        iretire_i[i] = 8'($urandom); ilastsize_i[i] = 1'($urandom);
        itype_i[i] = 3'($urandom_range(0, 7)); iaddr_i[i] = $urandom;
      end
      cause_i = $urandom; tval_i = $urandom; priv_i = 2'($urandom);
      te_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    rst_ni = 1'b1; valid_i = 2'b00; te_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
